// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the sweep FSM encoding, default sizes and packed-slice indexing.
package regfile_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } regState_t;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;

   // Low bit of lane idx in a vector packed from width-bit lanes.
   function automatic int sliceLo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port forwarding mux: storage value, or the same-cycle write data
// to the same register (highest write port wins), with register 0 forced to 0.
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = 5,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic [ADDR_W-1:0]        rdAddr,
   input  logic [DATA_W-1:0]        storeVal,
   input  logic [NUM_WR-1:0]        wrEn,
   input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
   input  logic [NUM_WR*DATA_W-1:0] wrData,
   output logic [DATA_W-1:0]        rdVal
);

   always_comb begin
      rdVal = storeVal;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wrEn[w] && (wrAddr[sliceLo(w, ADDR_W) +: ADDR_W] == rdAddr)) begin
            rdVal = wrData[sliceLo(w, DATA_W) +: DATA_W];
         end
      end
      if ((ZERO_REG != 0) && (rdAddr == '0)) begin
         rdVal = '0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, write-to-read bypass and a
// post-reset sweep that zeroes every entry before accesses are accepted.
//
// state   | meaning
// ST_INIT | clearing entry[ptr] one per cycle; accesses ignored, ready low
// ST_RUN  | normal read/write operation until the next reset
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   output logic                     ready
);

   regState_t               state;
   logic [ADDR_W-1:0]       ptr;
   logic [DATA_W-1:0]       mem [NUM_REGS];
   logic [NUM_RD*DATA_W-1:0] rdDataQ;
   logic [DATA_W-1:0]       bypassVal [NUM_RD];

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rdPort
      regfile_bypass #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG)
      ) u_bypass (
         .rdAddr   (rd_addr[k*ADDR_W +: ADDR_W]),
         .storeVal (mem[rd_addr[k*ADDR_W +: ADDR_W]]),
         .wrEn     (wr_en),
         .wrAddr   (wr_addr),
         .wrData   (wr_data),
         .rdVal    (bypassVal[k])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_INIT;
         ptr     <= '0;
         ready   <= 1'b0;
         rdDataQ <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               if (ptr == ADDR_W'(NUM_REGS - 1)) begin
                  state <= ST_RUN;
                  ready <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            ST_RUN: begin
               for (int k = 0; k < NUM_RD; k++) begin
                  if (rd_en[k]) begin
                     rdDataQ[sliceLo(k, DATA_W) +: DATA_W] <= bypassVal[k];
                  end
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   // Storage has no reset of its own; the sweep clears it. Later write ports
   // are assigned last so the highest index wins on an address collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == ST_INIT) begin
            mem[ptr] <= '0;
         end else begin
            for (int w = 0; w < NUM_WR; w++) begin
               if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[sliceLo(w, ADDR_W) +: ADDR_W] == '0))) begin
                  mem[wr_addr[sliceLo(w, ADDR_W) +: ADDR_W]] <= wr_data[sliceLo(w, DATA_W) +: DATA_W];
               end
            end
         end
      end
   end

   assign rd_data = rdDataQ;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus a randomized
// phase, all compared every cycle against a behavioural array model.
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NRD-1:0]    rdEn = '0;
   logic [NRD*AW-1:0] rdAddr = '0;
   logic [NRD*DW-1:0] rdData;
   logic [NWR-1:0]    wrEn = '0;
   logic [NWR*AW-1:0] wrAddr = '0;
   logic [NWR*DW-1:0] wrData = '0;
   logic              ready;

   int compared = 0;
   int mismatched = 0;

   logic [DW-1:0] mMem [NR];
   logic [DW-1:0] mRd [NRD];
   logic          mReady = 1'b0;
   int            initLeft = NR;

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NUM_RD   (NRD),
      .NUM_WR   (NWR),
      .ZERO_REG (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rdEn),
      .rd_addr (rdAddr),
      .rd_data (rdData),
      .wr_en   (wrEn),
      .wr_addr (wrAddr),
      .wr_data (wrData),
      .ready   (ready)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] portData(input int k);
      return rdData[k*DW +: DW];
   endfunction

   task automatic idle();
      rdEn = '0;
      wrEn = '0;
   endtask

   task automatic setRead(input int k, input int a);
      rdEn[k] = 1'b1;
      rdAddr[k*AW +: AW] = AW'(a);
   endtask

   task automatic setWrite(input int w, input int a, input logic [DW-1:0] d);
      wrEn[w] = 1'b1;
      wrAddr[w*AW +: AW] = AW'(a);
      wrData[w*DW +: DW] = d;
   endtask

   // Model: reset clears outputs and restarts a NUM_REGS-cycle init; in run,
   // writes apply in port order (address 0 discarded) and a read returns the
   // register contents as they stand after this cycle's writes.
   task automatic modelEdge();
      logic [DW-1:0] nxt [NR];
      int a;
      if (reset) begin
         mReady = 1'b0;
         initLeft = NR;
         for (int k = 0; k < NRD; k++) mRd[k] = '0;
      end else if (!mReady) begin
         initLeft--;
         if (initLeft == 0) begin
            mReady = 1'b1;
            for (int i = 0; i < NR; i++) mMem[i] = '0;
         end
      end else begin
         nxt = mMem;
         for (int w = 0; w < NWR; w++) begin
            a = int'(wrAddr[w*AW +: AW]);
            if (wrEn[w] && a != 0) nxt[a] = wrData[w*DW +: DW];
         end
         for (int k = 0; k < NRD; k++) begin
            if (rdEn[k]) mRd[k] = nxt[int'(rdAddr[k*AW +: AW])];
         end
         mMem = nxt;
      end
   endtask

   task automatic tick();
      modelEdge();
      @(posedge clk);
      #1;
      check("ready", DW'(ready), DW'(mReady));
      for (int k = 0; k < NRD; k++) check($sformatf("rd_data[%0d]", k), portData(k), mRd[k]);
   endtask

   task automatic waitReady(output int n);
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      // Reset then idle: ready low for exactly NUM_REGS cycles.
      idle();
      reset = 1'b1;
      tick();
      check("reset_rd0", portData(0), 32'h0);
      reset = 1'b0;
      waitReady(n);
      check("ready_latency", DW'(n), DW'(NR));

      for (int i = 0; i < NR; i += 2) begin
         idle();
         setRead(0, i);
         setRead(1, i + 1);
         tick();
         check("swept_p0", portData(0), 32'h0);
         check("swept_p1", portData(1), 32'h0);
      end

      // Write then read one cycle later.
      idle();
      setWrite(0, 5, 32'hDEADBEEF);
      tick();
      idle();
      setRead(0, 5);
      setRead(1, 6);
      tick();
      check("r5_read", portData(0), 32'hDEADBEEF);
      check("r6_read", portData(1), 32'h0);

      // Same-cycle bypass on both ports.
      idle();
      setWrite(0, 7, 32'h12345678);
      setRead(0, 7);
      setRead(1, 7);
      tick();
      check("bypass_p0", portData(0), 32'h12345678);
      check("bypass_p1", portData(1), 32'h12345678);

      // Held read data when rd_en is low.
      idle();
      tick();
      check("hold_p0", portData(0), 32'h12345678);

      // Zero register.
      idle();
      setWrite(0, 0, 32'hFFFFFFFF);
      setRead(0, 0);
      tick();
      check("r0_bypass", portData(0), 32'h0);
      idle();
      setRead(0, 0);
      tick();
      check("r0_read", portData(0), 32'h0);

      // Dual write to one register: port 1 wins, also through the bypass.
      idle();
      setWrite(0, 3, 32'hAAAA0000);
      setWrite(1, 3, 32'h5555FFFF);
      setRead(1, 3);
      tick();
      check("dual_bypass", portData(1), 32'h5555FFFF);
      idle();
      setRead(0, 3);
      tick();
      check("dual_r3", portData(0), 32'h5555FFFF);

      // Reset mid-RUN clears outputs and re-sweeps storage.
      idle();
      setWrite(0, 9, 32'h1);
      tick();
      idle();
      setRead(0, 9);
      tick();
      check("r9_before", portData(0), 32'h1);
      idle();
      reset = 1'b1;
      tick();
      check("run_reset_rd", portData(0), 32'h0);
      check("run_reset_ready", DW'(ready), 32'h0);
      reset = 1'b0;
      // Writes during the sweep must be ignored.
      setWrite(0, 9, 32'hCAFE0001);
      for (int i = 0; i < 10; i++) tick();
      // Second reset mid-INIT restarts the full sweep.
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      waitReady(n);
      check("reinit_latency", DW'(n), DW'(NR));
      idle();
      setRead(0, 9);
      tick();
      check("r9_after", portData(0), 32'h0);

      // Randomized traffic; narrow address range half the time for collisions.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NRD; k++) begin
            rdEn[k] = 1'($urandom_range(0, 1));
            rdAddr[k*AW +: AW] = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NR - 1));
         end
         for (int w = 0; w < NWR; w++) begin
            wrEn[w] = 1'($urandom_range(0, 1));
            wrAddr[w*AW +: AW] = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NR - 1));
            wrData[w*DW +: DW] = $urandom;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
